// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: captures register-file read data, immediate,
// register numbers and decode control, with flush, stall-hold and write-back forwarding.
module id_ex_stage #(
  parameter int DW        = 32,
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_e,
  input  logic          flush_e,
  input  logic [DW-1:0] rd1_d,
  input  logic [DW-1:0] rd2_d,
  input  logic [3:0]    ra1_d,
  input  logic [3:0]    ra2_d,
  input  logic [3:0]    wa3_d,
  input  logic [DW-1:0] extimm_d,
  input  logic [11:0]   ctrl_d,
  input  logic [3:0]    cond_d,
  input  logic          valid_d,
  input  logic          we3_w,
  input  logic [3:0]    wa3_w,
  input  logic [DW-1:0] wd3_w,
  output logic [DW-1:0] rd1_e,
  output logic [DW-1:0] rd2_e,
  output logic [3:0]    ra1_e,
  output logic [3:0]    ra2_e,
  output logic [3:0]    wa3_e,
  output logic [DW-1:0] extimm_e,
  output logic [11:0]   ctrl_e,
  output logic [3:0]    cond_e,
  output logic          valid_e
);

  // R15 reads already carry PC+8, so a write-back to R15 never replaces an operand.
  function automatic logic [DW-1:0] wb_fwd(
    input logic [3:0]    ra,
    input logic [DW-1:0] rd,
    input logic          we,
    input logic [3:0]    wa,
    input logic [DW-1:0] wd
  );
    if (BYPASS_WB && we && (wa == ra) && (ra != 4'hF))
      return wd;
    return rd;
  endfunction

  // ---- decode -> execute boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_e    <= '0;
      rd2_e    <= '0;
      ra1_e    <= '0;
      ra2_e    <= '0;
      wa3_e    <= '0;
      extimm_e <= '0;
      ctrl_e   <= '0;
      cond_e   <= '0;
      valid_e  <= 1'b0;
    end else if (flush_e) begin
      // Bubble clears register numbers too so it can never match the forwarding compares.
      rd1_e    <= '0;
      rd2_e    <= '0;
      ra1_e    <= '0;
      ra2_e    <= '0;
      wa3_e    <= '0;
      extimm_e <= '0;
      ctrl_e   <= '0;
      cond_e   <= '0;
      valid_e  <= 1'b0;
    end else if (stall_e) begin
      if (valid_e) begin
        rd1_e <= wb_fwd(ra1_e, rd1_e, we3_w, wa3_w, wd3_w);
        rd2_e <= wb_fwd(ra2_e, rd2_e, we3_w, wa3_w, wd3_w);
      end
    end else begin
      rd1_e    <= wb_fwd(ra1_d, rd1_d, we3_w, wa3_w, wd3_w);
      rd2_e    <= wb_fwd(ra2_d, rd2_d, we3_w, wa3_w, wd3_w);
      ra1_e    <= ra1_d;
      ra2_e    <= ra2_d;
      wa3_e    <= wa3_d;
      extimm_e <= extimm_d;
      ctrl_e   <= ctrl_d;
      cond_e   <= cond_d;
      valid_e  <= valid_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked against
// a behavioural model, with bypassing and non-bypassing instances side by side.
module tb_id_ex_stage;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall_e, flush_e;
  logic [DW-1:0] rd1_d, rd2_d, extimm_d;
  logic [3:0]    ra1_d, ra2_d, wa3_d, cond_d;
  logic [11:0]   ctrl_d;
  logic          valid_d;
  logic          we3_w;
  logic [3:0]    wa3_w;
  logic [DW-1:0] wd3_w;

  logic [DW-1:0] a_rd1, a_rd2, a_ext, b_rd1, b_rd2, b_ext;
  logic [3:0]    a_ra1, a_ra2, a_wa3, a_cond, b_ra1, b_ra2, b_wa3, b_cond;
  logic [11:0]   a_ctrl, b_ctrl;
  logic          a_valid, b_valid;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  wa3;
    logic [11:0] ctrl;
    logic [3:0]  cond;
    logic        valid;
  } st_t;

  st_t ma, mb;
  int  n_assert = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .BYPASS_WB(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
    .extimm_d(extimm_d), .ctrl_d(ctrl_d), .cond_d(cond_d), .valid_d(valid_d),
    .we3_w(we3_w), .wa3_w(wa3_w), .wd3_w(wd3_w),
    .rd1_e(a_rd1), .rd2_e(a_rd2), .ra1_e(a_ra1), .ra2_e(a_ra2), .wa3_e(a_wa3),
    .extimm_e(a_ext), .ctrl_e(a_ctrl), .cond_e(a_cond), .valid_e(a_valid)
  );

  id_ex_stage #(.DW(DW), .BYPASS_WB(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
    .extimm_d(extimm_d), .ctrl_d(ctrl_d), .cond_d(cond_d), .valid_d(valid_d),
    .we3_w(we3_w), .wa3_w(wa3_w), .wd3_w(wd3_w),
    .rd1_e(b_rd1), .rd2_e(b_rd2), .ra1_e(b_ra1), .ra2_e(b_ra2), .wa3_e(b_wa3),
    .extimm_e(b_ext), .ctrl_e(b_ctrl), .cond_e(b_cond), .valid_e(b_valid)
  );

  // True when this cycle's write-back updates architectural register r (R15 excluded).
  function automatic logic wb_updates(input logic [3:0] r);
    return we3_w && (wa3_w == r) && (r != 4'hF);
  endfunction

  // Execute-slot contents after the coming edge, from the current slot and inputs.
  function automatic st_t next_slot(input st_t cur, input bit byp);
    st_t n;
    n = cur;
    if (flush_e) begin
      n = '0;
    end else if (stall_e) begin
      if (byp && cur.valid && wb_updates(cur.ra1)) n.rd1 = wd3_w;
      if (byp && cur.valid && wb_updates(cur.ra2)) n.rd2 = wd3_w;
    end else begin
      n.rd1   = (byp && wb_updates(ra1_d)) ? wd3_w : rd1_d;
      n.rd2   = (byp && wb_updates(ra2_d)) ? wd3_w : rd2_d;
      n.ext   = extimm_d;
      n.ra1   = ra1_d;
      n.ra2   = ra2_d;
      n.wa3   = wa3_d;
      n.ctrl  = ctrl_d;
      n.cond  = cond_d;
      n.valid = valid_d;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    st_t bobs;
    bobs = '{rd1: b_rd1, rd2: b_rd2, ext: b_ext, ra1: b_ra1, ra2: b_ra2, wa3: b_wa3,
             ctrl: b_ctrl, cond: b_cond, valid: b_valid};
    chk({tag, ".rd1"},    128'(a_rd1),   128'(ma.rd1));
    chk({tag, ".rd2"},    128'(a_rd2),   128'(ma.rd2));
    chk({tag, ".extimm"}, 128'(a_ext),   128'(ma.ext));
    chk({tag, ".ra1"},    128'(a_ra1),   128'(ma.ra1));
    chk({tag, ".ra2"},    128'(a_ra2),   128'(ma.ra2));
    chk({tag, ".wa3"},    128'(a_wa3),   128'(ma.wa3));
    chk({tag, ".ctrl"},   128'(a_ctrl),  128'(ma.ctrl));
    chk({tag, ".cond"},   128'(a_cond),  128'(ma.cond));
    chk({tag, ".valid"},  128'(a_valid), 128'(ma.valid));
    chk({tag, ".nobyp"},  128'(bobs),    128'(mb));
  endtask

  task automatic step(input string tag);
    ma = next_slot(ma, 1'b1);
    mb = next_slot(mb, 1'b0);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_d();
    rd1_d    = $urandom;
    rd2_d    = $urandom;
    extimm_d = $urandom;
    ra1_d    = 4'($urandom_range(0, 15));
    ra2_d    = 4'($urandom_range(0, 15));
    wa3_d    = 4'($urandom_range(0, 15));
    ctrl_d   = 12'($urandom_range(0, 4095));
    cond_d   = 4'($urandom_range(0, 15));
    valid_d  = 1'b1;
    we3_w    = 1'b0;
    wa3_w    = 4'($urandom_range(0, 15));
    wd3_w    = $urandom;
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    ma = '0;
    mb = '0;
    #1 check_all(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] imm_q[$];
    rst_n = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    rand_d();
    ma = '0; mb = '0;
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    rst_n = 1'b1;

    // Asynchronous reset with a valid instruction in the slot, then recapture.
    rand_d();
    step("pre_rst");
    async_reset("async_rst");
    rand_d(); rd1_d = 32'h1234;
    step("cap_1234");
    chk("cap_1234.const", 128'(a_rd1), 128'(32'h1234));

    // Write-back bypass on capture.
    rand_d(); ra1_d = 4'd3; rd1_d = 32'hAAAA; ra2_d = 4'd4; rd2_d = 32'h5555;
    we3_w = 1'b1; wa3_w = 4'd3; wd3_w = 32'hBEEF;
    step("byp");
    chk("byp.rd1",   128'(a_rd1), 128'(32'hBEEF));
    chk("byp.rd2",   128'(a_rd2), 128'(32'h5555));
    chk("nobyp.rd1", 128'(b_rd1), 128'(32'hAAAA));

    // Both sources name the written register.
    rand_d(); ra1_d = 4'd6; ra2_d = 4'd6; we3_w = 1'b1; wa3_w = 4'd6; wd3_w = 32'hCAFE;
    step("byp_both");

    // R15 is never bypassed.
    rand_d(); ra2_d = 4'hF; rd2_d = 32'h108; we3_w = 1'b1; wa3_w = 4'hF; wd3_w = 32'h0;
    step("r15");
    chk("r15.rd2", 128'(a_rd2), 128'(32'h108));

    // Stall with a refresh of r5 in the second held cycle.
    rand_d(); ra1_d = 4'd5; rd1_d = 32'h11; ra2_d = 4'd2;
    step("stall_cap");
    stall_e = 1'b1;
    rand_d();
    step("stall1");
    rand_d(); we3_w = 1'b1; wa3_w = 4'd5; wd3_w = 32'h77;
    step("stall2");
    chk("stall2.rd1", 128'(a_rd1), 128'(32'h77));
    rand_d();
    step("stall3");
    stall_e = 1'b0;

    // Flush wins over stall.
    rand_d(); ctrl_d = 12'hFFF; ra1_d = 4'd7; wa3_d = 4'd9;
    step("pre_flush");
    rand_d(); flush_e = 1'b1; stall_e = 1'b1;
    step("flush");
    chk("flush.ctrl",  128'(a_ctrl),  128'(0));
    chk("flush.valid", 128'(a_valid), 128'(0));
    flush_e = 1'b0; stall_e = 1'b0;

    // Three back-to-back captures arrive in order one edge after presentation.
    for (int i = 0; i < 3; i++) begin
      rand_d();
      imm_q.push_back(extimm_d);
      step("b2b");
      chk("b2b.order", 128'(a_ext), 128'(imm_q.pop_front()));
    end

    // Reset while stalled leaves nothing pending once released.
    rand_d(); stall_e = 1'b1;
    step("stall_pre_rst");
    async_reset("rst_in_stall");
    rand_d(); we3_w = 1'b1; wa3_w = 4'd0; wd3_w = $urandom;
    step("post_rst_stall");
    stall_e = 1'b0;

    // Randomized traffic with small register numbers so forwarding hits often.
    for (int i = 0; i < 400; i++) begin
      rand_d();
      valid_d = ($urandom_range(0, 5) != 0);
      flush_e = ($urandom_range(0, 9) == 0);
      stall_e = ($urandom_range(0, 3) == 0);
      we3_w   = 1'($urandom_range(0, 1));
      wa3_w   = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 5));
      ra1_d   = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 5));
      ra2_d   = ($urandom_range(0, 4) == 0) ? ra1_d : 4'($urandom_range(0, 5));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
